// File: rtl/usb_fs_pkg.sv
// rtl/usb_fs_pkg.sv - shared line states, state codes and framing constants for the full-speed USB transmit path
package usb_fs_pkg;

  // Line states as {p, n}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_SYNC    = 3'd1,
    TX_DATA    = 3'd2,
    TX_ABORT   = 3'd3,
    TX_EOP_SE0 = 3'd4,
    TX_EOP_J   = 3'd5
  } tx_state_e;

  localparam logic [7:0] SYNC_BYTE    = 8'h80;
  localparam int         STUFF_LIMIT  = 6;
  localparam int         EOP_SE0_BITS = 2;

  // NRZI level register is 1 for J and 0 for K
  function automatic logic [1:0] line_of_level(input logic level);
    return level ? LINE_J : LINE_K;
  endfunction

endpackage

// File: rtl/usb_fs_tx_bitenc.sv
// rtl/usb_fs_tx_bitenc.sv - NRZI level register and bit-stuff run counter for the transmit path
module usb_fs_tx_bitenc
  import usb_fs_pkg::*;
(
  input  logic clk_48mhz,
  input  logic reset_n,
  input  logic bit_strobe,
  input  logic bit_value,
  input  logic se0_req,
  output logic nrzi_level,
  output logic stuff_pending
);

  logic [2:0] ones_cnt;

  // Each strobe loads the level of the bit about to go on the line; SE0 parks the level at J
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      nrzi_level <= 1'b1;
      ones_cnt   <= '0;
    end else if (bit_strobe) begin
      if (se0_req) begin
        nrzi_level <= 1'b1;
        ones_cnt   <= '0;
      end else if (!bit_value) begin
        nrzi_level <= ~nrzi_level;
        ones_cnt   <= '0;
      end else if (ones_cnt != 3'(STUFF_LIMIT)) begin
        ones_cnt <= ones_cnt + 3'd1;
      end
    end
  end

  // The run saturates at the limit so the abort pattern cannot wrap the counter
  assign stuff_pending = (ones_cnt == 3'(STUFF_LIMIT));

endmodule

// File: rtl/usb_fs_tx_serializer.sv
// rtl/usb_fs_tx_serializer.sv - full-speed USB TX serializer (SYNC, stuffing, NRZI, EOP); option USB_TX_STUFF_ABORT_EN
module usb_fs_tx_serializer
  import usb_fs_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic       pkt_start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic       tx_busy,
  output logic       tx_underrun,
  output logic       usb_p_tx,
  output logic       usb_n_tx,
  output logic       usb_tx_en
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [2:0] ST_IDLE    = 3'(TX_IDLE);
  localparam logic [2:0] ST_SYNC    = 3'(TX_SYNC);
  localparam logic [2:0] ST_DATA    = 3'(TX_DATA);
  localparam logic [2:0] ST_ABORT   = 3'(TX_ABORT);
  localparam logic [2:0] ST_EOP_SE0 = 3'(TX_EOP_SE0);
  localparam logic [2:0] ST_EOP_J   = 3'(TX_EOP_J);

  logic [2:0]       state;
  logic [DIV_W-1:0] div;
  logic [7:0]       shreg;      // shreg[0] is the data bit currently on the line
  logic [2:0]       bit_idx;    // index of the last data bit sent from shreg
  logic             last_flag;
  logic [2:0]       seq_cnt;    // bit counter for the abort and SE0 runs

  logic bit_end;
  logic pkt_accept;
  logic fetch;
  logic enc_strobe;
  logic enc_value;
  logic enc_se0;
  logic nrzi_level;
  logic stuff_pending;
  logic [1:0] line;

  usb_fs_tx_bitenc u_bitenc (
    .clk_48mhz     (clk_48mhz),
    .reset_n       (reset_n),
    .bit_strobe    (enc_strobe),
    .bit_value     (enc_value),
    .se0_req       (enc_se0),
    .nrzi_level    (nrzi_level),
    .stuff_pending (stuff_pending)
  );

  // Pick the next bit at each bit boundary and decide whether a byte is fetched now
  always_comb begin
    bit_end     = (div == DIV_W'(CLKS_PER_BIT - 1));
    pkt_accept  = (state == ST_IDLE) && pkt_start;
    // A pending stuff bit delays the fetch to the end of that stuff bit
    fetch       = ((state == ST_SYNC) || (state == ST_DATA)) && bit_end && !stuff_pending &&
                  (bit_idx == 3'd7) && !((state == ST_DATA) && last_flag);
    data_ready  = fetch;
    tx_underrun = fetch && !data_valid;
    enc_strobe  = 1'b0;
    enc_value   = 1'b1;
    enc_se0     = 1'b0;
    if (pkt_accept) begin
      enc_strobe = 1'b1;
      enc_value  = SYNC_BYTE[0];
    end else if (bit_end) begin
      case (state)
        ST_SYNC, ST_DATA: begin
          enc_strobe = 1'b1;
          if (stuff_pending) begin
            enc_value = 1'b0;
          end else if (bit_idx != 3'd7) begin
            enc_value = shreg[1];
          end else if (fetch && data_valid) begin
            enc_value = data_in[0];
          end else if (fetch) begin
`ifdef USB_TX_STUFF_ABORT_EN
            enc_value = 1'b1;
`else
            enc_se0   = 1'b1;
`endif
          end else begin
            enc_se0 = 1'b1;
          end
        end
        ST_ABORT: begin
          enc_strobe = 1'b1;
          if (seq_cnt == 3'd7) begin
            enc_se0 = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Bit divider, framing state machine and byte shifter
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      div       <= '0;
      shreg     <= '0;
      bit_idx   <= '0;
      last_flag <= 1'b0;
      seq_cnt   <= '0;
    end else begin
      if (pkt_accept || (state == ST_IDLE) || bit_end) begin
        div <= '0;
      end else begin
        div <= div + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (pkt_start) begin
            state     <= ST_SYNC;
            shreg     <= SYNC_BYTE;
            bit_idx   <= '0;
            last_flag <= 1'b0;
          end
        end
        ST_SYNC, ST_DATA: begin
          if (bit_end && !stuff_pending) begin
            if (bit_idx != 3'd7) begin
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end else if (fetch && data_valid) begin
              shreg     <= data_in;
              bit_idx   <= '0;
              last_flag <= data_last;
              state     <= ST_DATA;
            end else if (fetch) begin
              seq_cnt <= '0;
`ifdef USB_TX_STUFF_ABORT_EN
              state   <= ST_ABORT;
`else
              state   <= ST_EOP_SE0;
`endif
            end else begin
              seq_cnt <= '0;
              state   <= ST_EOP_SE0;
            end
          end
        end
        ST_ABORT: begin
          if (bit_end) begin
            if (seq_cnt == 3'd7) begin
              seq_cnt <= '0;
              state   <= ST_EOP_SE0;
            end else begin
              seq_cnt <= seq_cnt + 3'd1;
            end
          end
        end
        ST_EOP_SE0: begin
          if (bit_end) begin
            if (seq_cnt == 3'(EOP_SE0_BITS - 1)) begin
              seq_cnt <= '0;
              state   <= ST_EOP_J;
            end else begin
              seq_cnt <= seq_cnt + 3'd1;
            end
          end
        end
        ST_EOP_J: begin
          if (bit_end) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pin values follow the registered state so reset reaches the pins without a clock
  always_comb begin
    case (state)
      ST_IDLE:    line = LINE_J;
      ST_EOP_SE0: line = LINE_SE0;
      ST_EOP_J:   line = LINE_J;
      default:    line = line_of_level(nrzi_level);
    endcase
    usb_p_tx  = line[1];
    usb_n_tx  = line[0];
    usb_tx_en = (state != ST_IDLE);
    tx_busy   = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_usb_fs_tx_serializer.sv
// tb/tb_usb_fs_tx_serializer.sv - self-checking bench for usb_fs_tx_serializer
module tb_usb_fs_tx_serializer;

  localparam int CPB = 4;

  logic       clk_48mhz = 1'b0;
  logic       reset_n = 1'b0;
  logic       pkt_start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_last = 1'b0;
  logic       data_ready;
  logic       tx_busy;
  logic       tx_underrun;
  logic       usb_p_tx;
  logic       usb_n_tx;
  logic       usb_tx_en;

  usb_fs_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk_48mhz   (clk_48mhz),
    .reset_n     (reset_n),
    .pkt_start   (pkt_start),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_last   (data_last),
    .data_ready  (data_ready),
    .tx_busy     (tx_busy),
    .tx_underrun (tx_underrun),
    .usb_p_tx    (usb_p_tx),
    .usb_n_tx    (usb_n_tx),
    .usb_tx_en   (usb_tx_en)
  );

  always #10 clk_48mhz = ~clk_48mhz;

  typedef struct {
    logic [31:0] bytes;
    int          nb;
    bit          complete;
    int          restart_at;
    int          exp_clocks;
    int          exp_ready;
    int          exp_under;
    int          exp_gap;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] tx_bytes[$];
  logic [1:0] wave[$];
  logic [1:0] exp_wave[$];
  int         acc_cyc[$];
  int         n_ready, n_under, n_busy, n_busy_bad, timed_out, n_trail_en;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Expected line per clock: bit list with stuffing, then NRZI, then EOP
  task automatic build_expected(input bit complete);
    bit         bits[$];
    int         run;
    bit         b;
    logic       lvl;
    logic [7:0] sync_val;
    sync_val = 8'h80;
    bits.delete();
    exp_wave.delete();
    run = 0;
    for (int i = 0; i < 8 + 8 * tx_bytes.size(); i++) begin
      if (i < 8) b = sync_val[i];
      else b = tx_bytes[(i - 8) / 8][(i - 8) % 8];
      bits.push_back(b);
      run = b ? run + 1 : 0;
      if (run == 6) begin
        bits.push_back(1'b0);
        run = 0;
      end
    end
    if (!complete) begin
`ifdef USB_TX_STUFF_ABORT_EN
      repeat (8) bits.push_back(1'b1);
`endif
    end
    lvl = 1'b1;
    foreach (bits[i]) begin
      if (!bits[i]) lvl = ~lvl;
      repeat (CPB) exp_wave.push_back(lvl ? 2'b10 : 2'b01);
    end
    repeat (2 * CPB) exp_wave.push_back(2'b00);
    repeat (CPB) exp_wave.push_back(2'b10);
  endtask

  // Send tx_bytes as one packet, recording the line every clock while usb_tx_en is high
  task automatic run_pkt(input bit complete, input int restart_at);
    int idx;
    bit acc;
    wave.delete();
    acc_cyc.delete();
    n_ready = 0; n_under = 0; n_busy = 0; n_busy_bad = 0; timed_out = 1; n_trail_en = 0;
    idx = 0;
    @(posedge clk_48mhz); #1;
    for (int t = 0; t < 4000; t++) begin
      data_valid = (idx < tx_bytes.size());
      data_in    = data_valid ? tx_bytes[idx] : 8'($urandom);
      data_last  = data_valid && complete && (idx == tx_bytes.size() - 1);
      pkt_start  = (t == 0) || (t == restart_at);
      @(negedge clk_48mhz);
      if (data_ready) n_ready++;
      if (tx_underrun) n_under++;
      if (t > 0) begin
        if (!usb_tx_en) begin
          if (tx_busy) n_busy_bad++;
          timed_out = 0;
          break;
        end
        wave.push_back({usb_p_tx, usb_n_tx});
        if (tx_busy) n_busy++;
      end
      acc = data_ready && data_valid;
      @(posedge clk_48mhz); #1;
      if (acc) begin
        acc_cyc.push_back(t);
        idx++;
      end
    end
    pkt_start = 1'b0; data_valid = 1'b0; data_last = 1'b0;
    repeat (8) begin
      @(negedge clk_48mhz);
      if (usb_tx_en) n_trail_en++;
    end
    check("timeout", timed_out, 0);
  endtask

  task automatic compare_wave(input string name);
    int mism;
    mism = 0;
    for (int i = 0; i < wave.size() && i < exp_wave.size(); i++)
      if (wave[i] !== exp_wave[i]) mism++;
    check({name, "_clocks"}, wave.size(), exp_wave.size());
    check({name, "_wave_mismatch_cycles"}, mism, 0);
  endtask

  vec_t vecs[5];

  initial begin
    int         underrun_clocks;
    int         mism;
    int         nb;
    bit         comp;
    logic [7:0] rb;
    string      ack_sym;
    logic [1:0] sym_code;

`ifdef USB_TX_STUFF_ABORT_EN
    underrun_clocks = 108;
`else
    underrun_clocks = 76;
`endif
    vecs[0] = '{32'h000000D2, 1, 1'b1, -1, 76, 1, 0, 0};
    vecs[1] = '{32'h0000FFFF, 2, 1'b1, -1, 116, 2, 0, 0};
    vecs[2] = '{32'h000000D2, 1, 1'b0, -1, underrun_clocks, 2, 1, 0};
    vecs[3] = '{32'h000000D2, 1, 1'b1, 20, 76, 1, 0, 0};
    vecs[4] = '{32'h00800100, 3, 1'b1, -1, 140, 3, 0, 32};

    // Reset values
    repeat (3) @(negedge clk_48mhz);
    check("rst_tx_en", usb_tx_en, 0);
    check("rst_p", usb_p_tx, 1);
    check("rst_n", usb_n_tx, 0);
    check("rst_ready", data_ready, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_underrun", tx_underrun, 0);
    @(posedge clk_48mhz); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk_48mhz);

    // Directed table
    for (int v = 0; v < 5; v++) begin
      tx_bytes.delete();
      for (int k = 0; k < vecs[v].nb; k++) tx_bytes.push_back(vecs[v].bytes[8 * k +: 8]);
      build_expected(vecs[v].complete);
      run_pkt(vecs[v].complete, vecs[v].restart_at);
      check($sformatf("v%0d_clocks_const", v), wave.size(), vecs[v].exp_clocks);
      compare_wave($sformatf("v%0d", v));
      check($sformatf("v%0d_busy_clocks", v), n_busy, vecs[v].exp_clocks);
      check($sformatf("v%0d_busy_after_en", v), n_busy_bad, 0);
      check($sformatf("v%0d_ready_pulses", v), n_ready, vecs[v].exp_ready);
      check($sformatf("v%0d_underrun_pulses", v), n_under, vecs[v].exp_under);
      check($sformatf("v%0d_accepted", v), acc_cyc.size(), vecs[v].nb);
      check($sformatf("v%0d_no_second_pkt", v), n_trail_en, 0);
      if (vecs[v].exp_gap != 0)
        for (int k = 1; k < acc_cyc.size(); k++)
          check($sformatf("v%0d_accept_gap%0d", v, k), acc_cyc[k] - acc_cyc[k - 1], vecs[v].exp_gap);
      if (v == 0) begin
        // ACK waveform written out symbol by symbol
        ack_sym = "KJKJKJKKJJKJJKKK00J";
        mism = 0;
        for (int i = 0; i < 19; i++) begin
          case (ack_sym[i])
            "K":     sym_code = 2'b01;
            "J":     sym_code = 2'b10;
            default: sym_code = 2'b00;
          endcase
          for (int c = 0; c < CPB; c++)
            if (4 * i + c >= wave.size() || wave[4 * i + c] !== sym_code) mism++;
        end
        check("ack_symbol_mismatches", mism, 0);
      end
    end

    // Reset in the middle of a packet
    @(posedge clk_48mhz); #1;
    pkt_start = 1'b1; data_valid = 1'b1; data_in = 8'hD2; data_last = 1'b1;
    @(posedge clk_48mhz); #1;
    pkt_start = 1'b0;
    repeat (29) @(posedge clk_48mhz);
    #3;
    check("mid_pkt_tx_en", usb_tx_en, 1);
    reset_n = 1'b0;
    #1;
    check("async_rst_tx_en", usb_tx_en, 0);
    check("async_rst_p", usb_p_tx, 1);
    check("async_rst_n", usb_n_tx, 0);
    check("async_rst_busy", tx_busy, 0);
    @(posedge clk_48mhz); #1;
    data_valid = 1'b0; data_last = 1'b0;
    reset_n = 1'b1;
    tx_bytes.delete();
    tx_bytes.push_back(8'hD2);
    build_expected(1'b1);
    run_pkt(1'b1, -1);
    compare_wave("post_reset");

    // Random packets against the bit-list model
    for (int r = 0; r < 24; r++) begin
      nb = $urandom_range(4, 1);
      comp = ($urandom_range(3, 0) != 0);
      tx_bytes.delete();
      for (int k = 0; k < nb; k++) begin
        case ($urandom_range(2, 0))
          0:       rb = 8'hFF;
          1:       rb = 8'hFF ^ (8'd1 << $urandom_range(7, 0));
          default: rb = 8'($urandom);
        endcase
        tx_bytes.push_back(rb);
      end
      build_expected(comp);
      run_pkt(comp, -1);
      compare_wave($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_ready_pulses", r), n_ready, nb + (comp ? 0 : 1));
      check($sformatf("rnd%0d_underrun_pulses", r), n_under, comp ? 0 : 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
